// File: rtl/if_fetch_unit_pkg.sv
// Shared processor definitions for the instruction fetch path.
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h00000013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with flush, count and head.
// Head is read straight from storage, so it is registered state with no
// path from the push data.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty queue is ignored; a push into a full queue only
  // lands if the same cycle frees a slot.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_COUNT) || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !(reset || flush)) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time, queues responses
// with their PC, and presents the queue head to decode.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no request outstanding
// ST_WAIT    | one live request outstanding; response is pushed
// ST_DISCARD | one stale request outstanding; response is dropped
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW+1:0] OCC_LIMIT = (CW+2)'(DEPTH);

  fetch_state_e state;
  logic [31:0]  fpc;
  logic [31:0]  req_pc;
  logic [CW:0]  fifo_count;
  logic [CW+1:0] occ_next;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         push;
  logic         pop;
  logic         issue;

  // Outputs come from the queue's registered head; reset forces the idle view.
  assign if_valid = !reset && (fifo_count != '0);
  assign if_instr = if_valid ? head.instr : NOP;
  assign if_pc    = if_valid ? head.pc    : 32'd0;
  assign pop      = if_valid && id_ready;

  // Only a response to a live request that is not being flushed is kept.
  assign push       = !reset && !redirect_valid && (state == ST_WAIT) && imem_valid;
  assign push_entry = '{pc: req_pc, instr: imem_rdata};

  // Issuing requires room for this cycle's push plus the new response, so
  // the queue can never overflow.
  assign occ_next = {1'b0, fifo_count} + {{(CW+1){1'b0}}, push} - {{(CW+1){1'b0}}, pop};
  assign issue    = !reset && !redirect_valid && (occ_next < OCC_LIMIT) &&
                    ((state == ST_IDLE) || ((state == ST_WAIT) && imem_valid));

  // imem_req must follow imem_valid in the same cycle to keep one fetch per cycle.
  assign imem_req  = issue;
  assign imem_addr = reset ? RESET_PC : fpc;

  // Fetch FSM, fetch PC and PC of the outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      fpc    <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fpc   <= redirect_pc;
      state <= ((state != ST_IDLE) && !imem_valid) ? ST_DISCARD : ST_IDLE;
    end else begin
      if (issue) begin
        fpc    <= fpc + 32'd1;
        req_pc <= fpc;
      end
      case (state)
        ST_IDLE:    if (issue) state <= ST_WAIT;
        ST_WAIT:    if (imem_valid) state <= issue ? ST_WAIT : ST_IDLE;
        ST_DISCARD: if (imem_valid) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (push),
    .pop      (pop),
    .push_data(push_entry),
    .count    (fifo_count),
    .head     (head)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model answering addr+0x100, scoreboard of
// expected PCs pushed on each request and popped when decode accepts.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_ready = 1'b1;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mem_lat = 1;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] exp_pc_q[$];
  bit          seen_pc5 = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_pc = 32'd0;
  logic [31:0] prev_instr = 32'd0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc)
  );

  // Memory model: in-order responses after mem_lat cycles; stale ones still arrive.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_valid = 1'b1;
      imem_rdata = mem_addr_q[0] + 32'h100;
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 32'd0;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      exp_pc_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (if_valid !== 1'b1 || if_pc !== prev_pc || if_instr !== prev_instr) begin
          bad++;
          $display("FAIL stall_hold: got valid=%b pc=%h instr=%h, want valid=1 pc=%h instr=%h",
                   if_valid, if_pc, if_instr, prev_pc, prev_instr);
        end
      end
      if (if_valid !== 1'b1) begin
        total++;
        if (if_instr !== NOP_INSTR || if_pc !== 32'd0) begin
          bad++;
          $display("FAIL idle_outputs: got instr=%h pc=%h, want instr=%h pc=0", if_instr, if_pc, NOP_INSTR);
        end
      end
      if (if_valid === 1'b1 && if_pc === 32'd5) seen_pc5 = 1'b1;
      if (if_valid === 1'b1 && id_ready === 1'b1) begin
        total++;
        if (exp_pc_q.size() == 0) begin
          bad++;
          $display("FAIL stream_order: got unexpected pc=%h instr=%h, want nothing queued", if_pc, if_instr);
        end else begin
          e = exp_pc_q.pop_front();
          if (if_pc !== e || if_instr !== e + 32'h100) begin
            bad++;
            $display("FAIL stream_order: got pc=%h instr=%h, want pc=%h instr=%h", if_pc, if_instr, e, e + 32'h100);
          end
        end
      end
      prev_stall = (if_valid === 1'b1) && !id_ready && !redirect_valid;
      prev_pc    = if_pc;
      prev_instr = if_instr;
      if (redirect_valid) exp_pc_q.delete();
    end
    if (imem_req === 1'b1) begin
      exp_pc_q.push_back(imem_addr);
      mem_addr_q.push_back(imem_addr);
      mem_due_q.push_back(cyc + mem_lat);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (if_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_valid: got no if_valid within 50 cycles, want if_valid=1");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd0) begin
      bad++;
      $display("FAIL %s_req: got req=%b addr=%h, want req=0 addr=0", tag, imem_req, imem_addr);
    end
    total++;
    if (if_valid !== 1'b0 || if_instr !== NOP_INSTR || if_pc !== 32'd0) begin
      bad++;
      $display("FAIL %s_if: got valid=%b instr=%h pc=%h, want 0 %h 0", tag, if_valid, if_instr, if_pc, NOP_INSTR);
    end
  endtask

  task automatic check_pc(input string tag, input logic [31:0] pc);
    total++;
    if (if_valid !== 1'b1 || if_pc !== pc || if_instr !== pc + 32'h100) begin
      bad++;
      $display("FAIL %s: got valid=%b pc=%h instr=%h, want valid=1 pc=%h instr=%h",
               tag, if_valid, if_pc, if_instr, pc, pc + 32'h100);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    id_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      bad++;
      $display("FAIL first_req: got req=%b addr=%h, want req=1 addr=0", imem_req, imem_addr);
    end
    @(negedge clk);
    total++;
    if (if_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_latency: got if_valid=%b one cycle after request+1, want 0", if_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_pc("stream_start", 32'(i));
    end
  endtask

  task automatic test_stall_full();
    logic [31:0] hold_pc;
    step();
    id_ready = 1'b0;
    @(negedge clk);
    hold_pc = if_pc;
    repeat (9) @(negedge clk);
    total++;
    if (imem_req !== 1'b0 || int'(dut.u_fifo.count) != 4 || if_pc !== hold_pc) begin
      bad++;
      $display("FAIL stall_full: got req=%b count=%0d pc=%h, want req=0 count=4 pc=%h",
               imem_req, int'(dut.u_fifo.count), if_pc, hold_pc);
    end
    step();
    id_ready = 1'b1;
    @(negedge clk);
    check_pc("stall_resume", hold_pc);
    @(negedge clk);
    check_pc("stall_resume_next", hold_pc + 32'd1);
    repeat (6) step();
  endtask

  task automatic test_redirect_pending();
    bit ok;
    step();
    mem_lat = 3;
    redirect_valid = 1'b1;
    redirect_pc = 32'd5;
    seen_pc5 = 1'b0;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd5) begin
      bad++;
      $display("FAIL pending_req: got req=%b addr=%h, want req=1 addr=5", imem_req, imem_addr);
    end
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    mem_lat = 1;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    total++;
    if (dut.state !== ST_DISCARD) begin
      bad++;
      $display("FAIL discard_state: got state=%0d, want %0d", dut.state, ST_DISCARD);
    end
    wait_valid(ok);
    if (ok) check_pc("redirect_target", 32'h40);
    repeat (4) step();
    total++;
    if (seen_pc5) begin
      bad++;
      $display("FAIL no_pc5: got pc 5 delivered, want it dropped");
    end
  endtask

  task automatic test_simultaneous();
    bit found;
    bit ok;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (imem_valid === 1'b1 && if_valid === 1'b1) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL simul_setup: got no cycle with imem_valid and if_valid, want one");
    end
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    total++;
    if (if_valid !== 1'b0) begin
      bad++;
      $display("FAIL simul_flush: got if_valid=%b, want 0", if_valid);
    end
    wait_valid(ok);
    if (ok) check_pc("simul_target", 32'h200);
    repeat (3) step();
  endtask

  task automatic test_wrap();
    bit ok;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    wait_valid(ok);
    if (ok) begin
      check_pc("wrap_0", 32'hFFFF_FFFE);
      @(negedge clk);
      check_pc("wrap_1", 32'hFFFF_FFFF);
      @(negedge clk);
      check_pc("wrap_2", 32'h0000_0000);
    end
    repeat (3) step();
  endtask

  task automatic test_mid_reset();
    bit found;
    step();
    mem_lat = 2;
    id_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (int'(dut.u_fifo.count) == 3 && dut.state == ST_WAIT && imem_valid !== 1'b1) begin
        reset = 1'b1;
        mem_lat = 1;
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL midrst_setup: got no cycle with 3 queued and one outstanding, want one");
    end
    @(negedge clk);
    check_reset_outputs("midrst");
    step();
    reset = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    total++;
    if (imem_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      bad++;
      $display("FAIL midrst_restart: got late_valid=%b req=%b addr=%h, want 1 1 0", imem_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    total++;
    if (if_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_nopush: got if_valid=%b pc=%h, want if_valid=0", if_valid, if_pc);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_pc("midrst_stream", 32'(i));
    end
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_stall_full();
    test_redirect_pending();
    test_simultaneous();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: word address of the first fetch after reset.
REQ-002 SHALL have parameter DEPTH, default 4: number of prefetch queue entries; a power of two, at least 2.
REQ-003 SHALL have parameter NOP, default 32'h00000013: instruction value driven when the queue is empty.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high.
REQ-006 SHALL have port imem_req  output  1: one-cycle fetch request strobe.
REQ-007 SHALL have port imem_addr  output  32: word address for the request; valid while imem_req=1.
REQ-008 SHALL have port imem_valid  input  1: response strobe; responses arrive in order, 1 or more cycles after their request.
REQ-009 SHALL have port imem_rdata  input  32: response instruction; valid while imem_valid=1.
REQ-010 SHALL have port redirect_valid  input  1: branch/jump taken; flush and refetch.
REQ-011 SHALL have port redirect_pc  input  32: target word address.
REQ-012 SHALL have port id_ready  input  1: decode accepts this cycle; low stalls decode.
REQ-013 SHALL have port if_valid  output  1: the queue head is valid.
REQ-014 SHALL have port if_instr  output  32: queue head instruction; NOP when if_valid=0.
REQ-015 SHALL have port if_pc  output  32: queue head PC; 0 when if_valid=0.

Function
REQ-016 SHALL keep a fetch PC (fpc); each issued request uses imem_addr=fpc, then sets fpc to fpc+1 (word-addressed, modulo 2^32, so 32'hFFFFFFFF wraps to 0).
REQ-017 SHALL implement an FSM with three states:
- IDLE: no request outstanding.
- WAIT: one live request outstanding.
- DISCARD: one stale request outstanding.
REQ-018 SHALL allow at most one outstanding request.
REQ-019 SHALL assert imem_req only when all of the following hold: the state is IDLE, or it is WAIT with imem_valid=1; occupancy after this cycle's pop, plus 1, is at most DEPTH; and redirect_valid=0.
REQ-020 SHALL go IDLE->WAIT on issue; in WAIT with imem_valid=1, SHALL push {fpc_of_request, imem_rdata} and go to WAIT if it issues in the same cycle, else IDLE.
REQ-021 SHALL, on redirect_valid=1, empty the queue, set fpc=redirect_pc, and issue no request that cycle.
REQ-022 SHALL also, on redirect_valid=1, move to DISCARD if a request is outstanding and no response arrives that cycle, else to IDLE.
REQ-023 SHALL, in DISCARD, drop the response on imem_valid=1 without pushing it, and go to IDLE.
REQ-024 SHALL drop any response arriving in the same cycle as redirect_valid.
REQ-025 SHALL pop the queue head when if_valid=1 and id_ready=1.
REQ-026 SHALL handle simultaneous push and pop on a non-empty queue by keeping occupancy unchanged.
REQ-027 SHALL never overflow the queue (guaranteed by REQ-019), and SHALL ignore a pop on an empty queue.
REQ-028 SHALL register if_valid, if_instr and if_pc from the queue head, with no bypass from a same-cycle response to the outputs.
REQ-029 SHALL give latency of request at cycle N, imem_valid at N+1, if_valid at N+2; sustained throughput SHALL be one instruction per cycle with 1-cycle memory and id_ready held high.
REQ-030 SHALL hold if_instr and if_pc stable while if_valid=1 and id_ready=0.

Reset
REQ-031 SHALL, while reset=1, set:
- fpc=RESET_PC, state=IDLE, queue empty;
- imem_req=0, imem_addr=RESET_PC;
- if_valid=0, if_instr=NOP, if_pc=0.
REQ-032 SHALL issue its first request at RESET_PC in the first cycle after reset deasserts.
REQ-033 SHALL, if reset asserts while a request is outstanding, ignore the response to that request when it arrives after reset (state is IDLE, no push).
REQ-034 SHALL give reset priority over redirect_valid.

Structure
REQ-035 SHALL place the NOP encoding, the RESET_PC default and the FSM state enumeration in the shared processor package.
REQ-036 SHALL instantiate one sub-module, fetch_fifo: a DEPTH-entry, 64-bit-wide synchronous FIFO with push/pop/flush, count and head outputs.
REQ-037 SHALL keep the FSM, fpc and request logic in if_fetch_unit.
REQ-038 SHALL keep the RTL within 120-400 lines total.

Verification
REQ-039 Reset and stream: RESET_PC=0, 1-cycle memory returning imem_rdata=addr+32'h100, id_ready=1 -> if_valid rises 2 cycles after reset drops; if_pc reads 0,1,2,3 on consecutive cycles with if_instr 0x100,0x101,0x102,0x103.
REQ-040 Stall/full: id_ready=0 for 10 cycles -> occupancy saturates at 4; imem_req low while full; if_pc held at the same value; resumes in order with no loss or duplicates.
REQ-041 Redirect with response pending: request at addr 5 outstanding, redirect_pc=0x40, memory responds 3 cycles later -> that response is dropped (DISCARD); next if_pc=0x40; no PC 5 ever appears.
REQ-042 Simultaneous events: redirect_valid and imem_valid in the same cycle, with a non-empty queue -> queue emptied, response dropped, if_valid=0 next cycle, first post-redirect if_pc equals redirect_pc.
REQ-043 Wrap: redirect_pc=32'hFFFFFFFE -> if_pc sequence FFFFFFFE, FFFFFFFF, 00000000.
REQ-044 Mid-operation reset: assert reset for 1 cycle while the queue holds 3 entries and a request is outstanding -> all outputs at reset values; the late response causes no push; the fetch stream restarts at RESET_PC.
